vmem_sequencer: RTL

- Controller that sequences the 4-lane vector load/store (VLOAD/VSTORE) byte transfers between the single-port 8-bit data memory and the vector datapath (X1, T0..T3, VRF).
- On a start from the main control FSM, it takes ownership of the memory port through a req/gnt handshake and issues one byte access per cycle at base, base+1, base+2 and base+3.
- It drives the T-register lane loads, the MemIn lane select and VoutSel, then pulses done. For loads it also pulses vrf_write.

---
 rtl/vec_pkg.sv | 19 +
 rtl/vmem_rd_tracker.sv | 46 ++++
 rtl/vmem_sequencer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/vec_pkg.sv
// Shared encodings for the vector load/store sequencer: FSM states, lane count
// and the MemIn / VoutSel mux codes.
package vec_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);

  localparam logic [2:0] SCALAR_SEL = 3'd4;

  localparam logic VOUT_ALU = 1'b0;
  localparam logic VOUT_MEM = 1'b1;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WAIT_GNT = 3'd1;
  localparam logic [2:0] ST_ISSUE    = 3'd2;
  localparam logic [2:0] ST_DRAIN    = 3'd3;
  localparam logic [2:0] ST_DONE     = 3'd4;

endpackage

// File: rtl/vmem_rd_tracker.sv
// Tracks outstanding memory reads as a READ_LATENCY-deep {valid, lane} shift
// register; the final stage decodes into the one-hot T-register load enables.
import vec_pkg::*;

module vmem_rd_tracker #(
  parameter int READ_LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  input  logic [LANE_W-1:0] lane_i,
  output logic [LANES-1:0]  t_load_o,
  output logic              empty_o,
  output logic              last_o
);

  logic [READ_LATENCY-1:0] vld_q;
  logic [LANE_W-1:0]       lane_q [READ_LATENCY];
  logic                    upstream_vld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vld_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) lane_q[i] <= '0;
    end else begin
      vld_q[0]  <= valid_i;
      lane_q[0] <= lane_i;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_q[i]  <= vld_q[i-1];
        lane_q[i] <= lane_q[i-1];
      end
    end
  end

  // last_o: nothing is queued behind the final stage, so the pipeline is
  // empty after this edge unless a new read enters.
  always_comb begin
    upstream_vld = 1'b0;
    for (int i = 0; i < READ_LATENCY - 1; i++) upstream_vld = upstream_vld | vld_q[i];
  end

  assign t_load_o = vld_q[READ_LATENCY-1] ? (LANES'(1) << lane_q[READ_LATENCY-1]) : '0;
  assign empty_o  = ~|vld_q;
  assign last_o   = ~upstream_vld;

endmodule

// File: rtl/vmem_sequencer.sv
// Sequences the four byte accesses of a VLOAD/VSTORE over the shared 8-bit
// memory port and steers the T-register loads, MemIn lane select and VoutSel.
import vec_pkg::*;

module vmem_sequencer #(
  parameter int ADDR_W       = 8,
  parameter int READ_LATENCY = 1,
  parameter int SEL_W        = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_gnt,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [SEL_W-1:0]  mem_in_sel,
  output logic              vout_sel,
  output logic [LANES-1:0]  t_load,
  output logic              vrf_write,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state
);

  // Handshake: mem_req is held from WAIT_GNT through the last ISSUE cycle; an
  // access happens only in ISSUE cycles where mem_gnt is sampled high, and a
  // low mem_gnt stalls the sequence without losing any lane.

  logic [2:0]        state_q, state_d;
  logic [LANE_W-1:0] cnt_q, cnt_d;
  logic              store_q, store_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;

  logic              issue;
  logic              last_lane;
  logic [ADDR_W-1:0] issue_addr;
  logic              rd_empty;
  logic              rd_last;

  assign issue      = (state_q == ST_ISSUE) && mem_gnt;
  assign last_lane  = (cnt_q == LANE_W'(LANES - 1));
  assign issue_addr = base_q + ADDR_W'(cnt_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    store_d     = store_q;
    base_d      = base_q;
    last_addr_d = last_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          store_d = is_store;
          base_d  = base_addr;
          cnt_d   = '0;
          state_d = ST_WAIT_GNT;
        end
      end
      ST_WAIT_GNT: begin
        if (mem_gnt) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue) begin
          cnt_d       = cnt_q + LANE_W'(1);
          last_addr_d = issue_addr;
          if (last_lane) state_d = store_q ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (rd_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      store_q     <= 1'b0;
      base_q      <= '0;
      last_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      store_q     <= store_d;
      base_q      <= base_d;
      last_addr_q <= last_addr_d;
    end
  end

  vmem_rd_tracker #(
    .READ_LATENCY (READ_LATENCY)
  ) u_rd_tracker (
    .clk_i    (clock),
    .rst_ni   (reset),
    .valid_i  (issue && !store_q),
    .lane_i   (cnt_q),
    .t_load_o (t_load),
    .empty_o  (rd_empty),
    .last_o   (rd_last)
  );

  assign mem_req    = (state_q == ST_WAIT_GNT) || (state_q == ST_ISSUE);
  assign mem_read   = issue && !store_q;
  assign mem_write  = issue && store_q;
  assign mem_addr   = issue ? issue_addr : last_addr_q;
  assign mem_in_sel = (issue && store_q) ? SEL_W'(cnt_q) : SEL_W'(SCALAR_SEL);

  // VoutSel stays on memory across grant stalls between load lanes.
  assign vout_sel = (!store_q && (((state_q == ST_ISSUE) && (issue || cnt_q != '0)) ||
                                  ((state_q == ST_DRAIN) && !rd_empty)))
                    ? VOUT_MEM : VOUT_ALU;

  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign vrf_write = (state_q == ST_DONE) && !store_q;
  assign dbg_state = state_q;

endmodule
